pipe_stage_hs: RTL and testbench

- Generic, parametrised inter-stage pipeline register for the 5-stage core. Replaces fixed per-stage latches that have only a global write enable.
- Carries an arbitrary packed payload plus a 1-bit branch-taken sideband.
- Uses a valid/ready handshake with a 2-entry skid buffer, so upstream stalls are not combinational through the stage.
- Adds a synchronous flush for branch squash and a saturating stall-cycle counter for performance monitoring.

---
 rtl/pipe_pkg.sv | 62 ++++++
 rtl/sat_counter.sv | 22 ++
 rtl/pipe_stage_hs.sv | 111 +++++++++++
 tb/tb_pipe_stage_hs.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: stage occupancy encoding, counter defaults and the
// per-stage payload layouts that instantiating modules flatten onto in_data.
package pipe_pkg;

    localparam int unsigned PIPE_STAGE_CNT_W_DEFAULT = 8;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned IMM_W  = 16;
    localparam int unsigned OP_W   = 6;

    // Encoded as {out_valid, skid_valid}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b10,
        TWO   = 2'b11
    } stage_state_t;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_curr;
        logic [XLEN-1:0] pc_next;
    } if_id_payload_t;

    typedef struct packed {
        logic [XLEN-1:0]  rs_data;
        logic [XLEN-1:0]  rt_data;
        logic [XLEN-1:0]  pc_curr;
        logic [XLEN-1:0]  pc_next;
        logic [IMM_W-1:0] imm;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [OP_W-1:0]  op;
    } id_ex_payload_t;

    typedef struct packed {
        logic [XLEN-1:0]  mem_addr;
        logic [XLEN-1:0]  alu_data;
        logic [XLEN-1:0]  pc_curr;
        logic [XLEN-1:0]  pc_next;
        logic [IMM_W-1:0] imm;
        logic [REG_W-1:0] rs;
        logic [REG_W-1:0] rt;
        logic [REG_W-1:0] rd;
        logic [OP_W-1:0]  op;
    } ex_mem_payload_t;

    typedef struct packed {
        logic [XLEN-1:0]  wb_data;
        logic [XLEN-1:0]  pc_curr;
        logic [REG_W-1:0] rd;
        logic             wb_en;
        logic [OP_W-1:0]  op;
    } mem_wb_payload_t;

    localparam int unsigned IF_ID_W  = $bits(if_id_payload_t);
    localparam int unsigned ID_EX_W  = $bits(id_ex_payload_t);
    localparam int unsigned EX_MEM_W = $bits(ex_mem_payload_t);
    localparam int unsigned MEM_WB_W = $bits(mem_wb_payload_t);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; shared by the
// performance-monitoring counters.
module sat_counter #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}};

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != MAX_VAL)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, 2-entry skid
// buffer, synchronous branch flush and a saturating stall-cycle counter.
module pipe_stage_hs
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned CNT_W      = PIPE_STAGE_CNT_W_DEFAULT,
    parameter bit          FLUSH_SKID = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_br,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_br,
    output logic [CNT_W-1:0]  stall_cnt
);

    if ((DATA_W < 1) || (DATA_W > 256)) begin : g_bad_data_w
        $error("pipe_stage_hs: DATA_W must be in 1..256");
    end

    stage_state_t      state;
    logic [DATA_W-1:0] skid_data;
    logic              skid_br;
    logic              skid_valid;
    logic              in_xfer;
    logic              out_xfer;

    // Valid flags are the state flops themselves.
    assign out_valid  = state[1];
    assign skid_valid = state[0];
    assign in_xfer    = in_valid & in_ready;
    assign out_xfer   = out_valid & out_ready;

    // Occupancy FSM: output entry, skid entry and registered in_ready.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_data  <= '0;
            out_br    <= 1'b0;
            skid_data <= '0;
            skid_br   <= 1'b0;
        end else begin
            unique case (state)
                EMPTY: begin
                    in_ready <= 1'b1;
                    if (!flush && in_xfer) begin
                        out_data <= in_data;
                        out_br   <= in_br;
                        state    <= ONE;
                    end
                end
                ONE: begin
                    if (flush) begin
                        state    <= EMPTY;
                        in_ready <= 1'b1;
                    end else if (in_xfer && out_xfer) begin
                        out_data <= in_data;
                        out_br   <= in_br;
                        in_ready <= 1'b1;
                    end else if (in_xfer) begin
                        skid_data <= in_data;
                        skid_br   <= in_br;
                        state     <= TWO;
                        in_ready  <= 1'b0;
                    end else if (out_xfer) begin
                        state    <= EMPTY;
                        in_ready <= 1'b1;
                    end
                end
                TWO: begin
                    // Flush either empties the stage or promotes the skid entry.
                    if (flush && FLUSH_SKID) begin
                        state    <= EMPTY;
                        in_ready <= 1'b1;
                    end else if (flush || out_xfer) begin
                        out_data  <= skid_data;
                        out_br    <= skid_br;
                        skid_data <= '0;
                        skid_br   <= 1'b0;
                        state     <= ONE;
                        in_ready  <= 1'b1;
                    end else begin
                        in_ready <= 1'b0;
                    end
                end
                default: begin
                    state    <= EMPTY;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .clr_n (rst),
        .inc   (out_valid & ~out_ready),
        .count (stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Bench for pipe_stage_hs: three parameterisations driven in lockstep against
// a depth-2 FIFO model, plus directed scenarios with literal expectations.
module tb_pipe_stage_hs;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_br;
    logic        out_ready;

    logic        ir   [3];
    logic        ov   [3];
    logic [15:0] od   [3];
    logic        ob   [3];
    logic [7:0]  sc0;
    logic [7:0]  sc1;
    logic [3:0]  sc2;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    // Model: per instance a FIFO of up to two {br,data} words plus stall count.
    logic [16:0] ment [3][2];
    int          mn   [3];
    int          ms   [3];
    int          smax [3];
    bit          fs   [3];
    int          pops0 = 0;

    always #5 clk = ~clk;

    pipe_stage_hs #(.DATA_W(16), .CNT_W(8), .FLUSH_SKID(1'b1)) dut_a (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[0]),
        .in_data(in_data), .in_br(in_br), .out_valid(ov[0]), .out_ready(out_ready),
        .out_data(od[0]), .out_br(ob[0]), .stall_cnt(sc0));

    pipe_stage_hs #(.DATA_W(16), .CNT_W(8), .FLUSH_SKID(1'b0)) dut_b (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[1]),
        .in_data(in_data), .in_br(in_br), .out_valid(ov[1]), .out_ready(out_ready),
        .out_data(od[1]), .out_br(ob[1]), .stall_cnt(sc1));

    pipe_stage_hs #(.DATA_W(16), .CNT_W(4), .FLUSH_SKID(1'b1)) dut_c (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(ir[2]),
        .in_data(in_data), .in_br(in_br), .out_valid(ov[2]), .out_ready(out_ready),
        .out_data(od[2]), .out_br(ob[2]), .stall_cnt(sc2));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic void mpop(input int k);
        ment[k][0] = ment[k][1];
        mn[k]      = mn[k] - 1;
    endfunction

    // Model update from the inputs seen at each rising edge.
    initial begin
        smax[0] = 255; smax[1] = 255; smax[2] = 15;
        fs[0] = 1'b1;  fs[1] = 1'b0;  fs[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mn[k] = 0;
            ms[k] = 0;
        end
        forever begin
            @(posedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!rst) begin
                    mn[k] = 0;
                    ms[k] = 0;
                end else begin
                    bit mv;
                    bit mr;
                    mv = (mn[k] > 0);
                    mr = (mn[k] < 2);
                    if (mv && !out_ready && ms[k] < smax[k]) ms[k]++;
                    if (flush) begin
                        if (fs[k]) mn[k] = 0;
                        else if (mn[k] > 0) mpop(k);
                    end else begin
                        if (mv && out_ready) begin
                            mpop(k);
                            if (k == 0) pops0++;
                        end
                        if (in_valid && mr) begin
                            ment[k][mn[k]] = {in_br, in_data};
                            mn[k] = mn[k] + 1;
                        end
                    end
                end
            end
        end
    end

    // Per-cycle comparison of every instance against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                int sc [3];
                sc[0] = int'(sc0);
                sc[1] = int'(sc1);
                sc[2] = int'(sc2);
                for (int k = 0; k < 3; k++) begin
                    chk($sformatf("u%0d_out_valid", k), int'(ov[k]), int'(mn[k] > 0));
                    chk($sformatf("u%0d_in_ready", k), int'(ir[k]), int'(mn[k] < 2));
                    chk($sformatf("u%0d_stall_cnt", k), sc[k], ms[k]);
                    if (mn[k] > 0) begin
                        chk($sformatf("u%0d_out_data", k), int'(od[k]), int'(ment[k][0][15:0]));
                        chk($sformatf("u%0d_out_br", k), int'(ob[k]), int'(ment[k][0][16]));
                    end
                end
            end
        end
    end

    initial begin
        int base;
        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_br = 1'b0; out_ready = 1'b0;

        // Reset then a single word
        tick(); tick();
        rst = 1'b1;
        chk_en = 1'b1;
        chk("rst_out_valid", int'(ov[0]), 0);
        chk("rst_in_ready", int'(ir[0]), 1);
        chk("rst_out_data", int'(od[0]), 0);
        chk("rst_stall", int'(sc0), 0);
        in_valid = 1'b1; in_data = 16'hA5A5; in_br = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; in_br = 1'b0;
        chk("single_valid", int'(ov[0]), 1);
        chk("single_data", int'(od[0]), 32'hA5A5);
        chk("single_br", int'(ob[0]), 1);
        chk("single_in_ready", int'(ir[0]), 1);
        tick();

        // Streaming at one word per cycle
        base = pops0;
        for (int i = 0; i < 100; i++) begin
            in_valid = 1'b1; in_data = 16'(i + 16'h0100);
            tick();
        end
        in_valid = 1'b0;
        tick();
        chk("stream_count", pops0 - base, 100);
        chk("stream_stall", int'(sc0), 0);

        // Back-pressure fill then drain
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0001; tick();
        in_data = 16'h0002; tick();
        in_valid = 1'b0;
        chk("bp_in_ready", int'(ir[0]), 0);
        chk("bp_hold_data", int'(od[0]), 1);
        chk("bp_model_two", mn[0], 2);
        out_ready = 1'b1;
        tick();
        chk("bp_drain1_data", int'(od[0]), 2);
        chk("bp_drain1_ready", int'(ir[0]), 1);
        tick();
        chk("bp_drained", int'(ov[0]), 0);

        // Flush while holding two entries, with an input on offer
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0003; tick();
        in_data = 16'h0004; tick();
        flush = 1'b1; in_data = 16'h0005; tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        chk("flush1_valid", int'(ov[0]), 0);
        chk("flush1_ready", int'(ir[0]), 1);
        chk("flush0_valid", int'(ov[1]), 1);
        chk("flush0_data", int'(od[1]), 4);
        tick();
        chk("flush0_no_5", int'(ov[1]), 0);
        tick();

        // Stall counter saturation on the 4-bit instance
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 16'h0006; tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        chk("sat_c", int'(sc2), 15);
        chk("sat_model", ms[2], 15);
        rst = 1'b0; tick();
        rst = 1'b1;
        chk("sat_clear_c", int'(sc2), 0);
        chk("sat_clear_a", int'(sc0), 0);

        // Reset in the middle of a full stage
        in_valid = 1'b1; in_data = 16'h0007; tick();
        in_data = 16'h0008; tick();
        in_valid = 1'b0;
        rst = 1'b0; out_ready = 1'b1; tick();
        rst = 1'b1;
        chk("midrst_valid", int'(ov[0]), 0);
        chk("midrst_data", int'(od[0]), 0);
        chk("midrst_ready", int'(ir[0]), 1);
        tick();
        chk("midrst_nodeliver", int'(ov[0]), 0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 16) == 0;
            rst       = ($urandom % 200) != 0;
            in_data   = 16'($urandom);
            in_br     = 1'($urandom);
            tick();
        end
        in_valid = 1'b0; flush = 1'b0; rst = 1'b1; out_ready = 1'b1;
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
